fp_div_seq: RTL and testbench
=============================

Name: fp_div_seq

Overview:
Sequential single-precision (IEEE-754 binary32) divider, fp_Z = fp_X / fp_Y. It is the inverse-operation companion to the FPU multiplier and shares its flag conventions, its rounding-mode encoding and its subnormal-as-zero policy. It uses a radix-2 restoring quotient loop, one quotient bit per cycle, with a start/done handshake into the FPU issue logic.

Parameters:
- QBITS, 27, quotient bits produced by the iteration loop (hidden + 23 fraction + guard + round + 1 normalization spare).
- NAN_CANON, 32'h7FC00000, canonical quiet NaN returned for invalid operations.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  accept operands; honoured only when busy=0
- fp_X  in  32  dividend
- fp_Y  in  32  divisor
- r_mode  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 behave as RNE
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, fp_Z and flags valid
- fp_Z  out  32  quotient; held until the next done
- ovrf  out  1  overflow
- udrf  out  1  underflow (flush to zero)
- dz  out  1  divide by zero
- inv  out  1  invalid (NaN result)

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE. Asserting rst mid-operation aborts the operation with no done pulse.
- FSM states: IDLE -> UNPACK -> ITER (QBITS cycles) -> NORM -> ROUND -> IDLE.
- Timing: start sampled high in IDLE at edge 0 gives done high during cycle 30, and busy=1 during cycles 1..30.
- Operands and r_mode are registered at start. start while busy=1 is ignored.
- done and busy are high together on the final cycle. A start in the cycle after done is accepted.
- Operands with exponent 0 are treated as signed zero (DAZ). The result sign is always X[31]^Y[31], except for NaN results.
- Special cases are decided in UNPACK but still run the full latency (see optional feature). Rules in priority order:
  - NaN operand, 0/0 or inf/inf: NAN_CANON, inv=1.
  - X=inf: signed inf.
  - Y=inf: signed zero.
  - Y=0 with X finite nonzero: signed inf, dz=1.
  - X=0: signed zero.
- ITER: mx={1,frc_X} is divided by my={1,frc_Y}; q[26] has weight 2^0. Each cycle the partial remainder is compared with my, one q bit is set, and the remainder is shifted left. sticky = OR of the final remainder.
- NORM:
  - If q[26]=1: mant=q[26:3], G=q[2], R=q[1], S=q[0]|sticky.
  - Else: shift left 1 and subtract 1 from the exponent.
  - E = eX - eY + 127 - shift, computed as a 10-bit signed value.
- ROUND, where inexact = G|R|S:
  - RNE: increment if G&(R|S|mant[0]).
  - RTZ: never increment.
  - RDN: increment if sign & inexact.
  - RUP: increment if !sign & inexact.
  - RMM: increment if G.
- A carry out of the 24-bit mantissa sets mant to 1.0 and adds 1 to E.
- Overflow, E>=255 after rounding, sets ovrf=1. The result by mode:
  - RNE/RMM: signed inf.
  - RTZ: signed max finite 0x7F7FFFFF.
  - RDN: +max or -inf.
  - RUP: +inf or -max.
- Underflow, E<=0: result is signed zero, udrf=1 (no subnormal output).
- Flags are cleared at every done and are valid only with done.

Optional Feature:
- Macro FP_DIV_FAST_SPECIAL_EN.
- Defined: a special-case operand skips ITER/NORM/ROUND, so done pulses in cycle 2 and busy falls after it. Normal operands are unchanged at 30 cycles.
- Undefined: all operations take 30 cycles, and specials simply discard the quotient.

Test Plan:
- X=0x40C00000, Y=0x40000000, RNE, start -> done in cycle 30, fp_Z=0x40400000, all flags 0.
- X=0x3F800000, Y=0x40400000: RNE -> 0x3EAAAAAB; RTZ -> 0x3EAAAAAA; RMM -> 0x3EAAAAAB.
- X=0xBF800000, Y=0x40400000: RDN -> 0xBEAAAAAB; RUP -> 0xBEAAAAAA.
- Specials:
  - 0x3F800000/0x00000000 -> 0x7F800000, dz=1.
  - 0/0 -> 0x7FC00000, inv=1.
  - 0x3F800000/0x00000001 (subnormal) -> 0x7F800000, dz=1.
  - With FP_DIV_FAST_SPECIAL_EN defined -> done in cycle 2.
- Overflow and underflow:
  - 0x7F000000/0x3E800000, RNE -> 0x7F800000, ovrf=1.
  - Same operands, RTZ -> 0x7F7FFFFF, ovrf=1.
  - 0x00800000/0x7F000000 -> 0x00000000, udrf=1.
- Handshake and reset:
  - start pulsed again at cycle 10 -> ignored, one done at cycle 30.
  - rst asserted at cycle 15 -> busy=0 and fp_Z=0 immediately, no done.
  - A new start after reset completes 30 cycles later with the correct result.

Source files
------------

// File: rtl/fp_div_seq.sv
// Sequential binary32 divider fp_Z = fp_X / fp_Y, radix-2 restoring loop, one quotient bit per cycle.
// Latency: start sampled at edge 0 -> done in cycle 30; specials finish in cycle 2 with FP_DIV_FAST_SPECIAL_EN.
// Backpressure: none; start is honoured only while busy=0, otherwise it is dropped.
//
// Ports: clk, rst (async, active high), start, fp_X/fp_Y operands, r_mode rounding mode
//        (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, others RNE); busy, done (1-cycle pulse),
//        fp_Z result (held until next done), ovrf/udrf/dz/inv flags (valid with done).
// Optional macro: FP_DIV_FAST_SPECIAL_EN - special-case operands bypass the iteration loop.
module fp_div_seq #(
    parameter int          QBITS     = 27,
    parameter logic [31:0] NAN_CANON = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] fp_X,
    input  logic [31:0] fp_Y,
    input  logic [2:0]  r_mode,
    output logic        busy,
    output logic        done,
    output logic [31:0] fp_Z,
    output logic        ovrf,
    output logic        udrf,
    output logic        dz,
    output logic        inv
);
    localparam int          CW      = $clog2(QBITS);
    localparam logic [30:0] INF_MAG = 31'h7F800000;
    localparam logic [30:0] MAX_MAG = 31'h7F7FFFFF;

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ITER, S_NORM, S_ROUND} state_t;

    state_t              state_q;
    logic [31:0]         x_q, y_q;
    logic [2:0]          rm_q;
    logic signed [9:0]   exp_q;
    logic [24:0]         rem_q;
    logic [23:0]         my_q;
    logic [QBITS-1:0]    q_q;
    logic [CW-1:0]       cnt_q;
    logic                spec_q, spec_dz_q, spec_inv_q;
    logic [31:0]         spec_z_q;
    logic                busy_q, done_q, ovrf_q, udrf_q, dz_q, inv_q;
    logic [31:0]         z_q;

    // Operand decode (operands with exponent 0 count as zero)
    logic [7:0]  xe, ye;
    logic [22:0] xf, yf;
    logic        x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, res_sign;
    assign xe       = x_q[30:23];
    assign ye       = y_q[30:23];
    assign xf       = x_q[22:0];
    assign yf       = y_q[22:0];
    assign x_nan    = (xe == 8'hFF) && (xf != '0);
    assign y_nan    = (ye == 8'hFF) && (yf != '0);
    assign x_inf    = (xe == 8'hFF) && (xf == '0);
    assign y_inf    = (ye == 8'hFF) && (yf == '0);
    assign x_zero   = (xe == 8'h00);
    assign y_zero   = (ye == 8'h00);
    assign res_sign = x_q[31] ^ y_q[31];

    logic signed [9:0] exp_d;
    assign exp_d = $signed({2'b00, xe}) - $signed({2'b00, ye}) + 10'sd127;

    logic        spec_d, spec_dz_d, spec_inv_d;
    logic [31:0] spec_z_d;
    always_comb begin
        spec_d     = 1'b1;
        spec_z_d   = '0;
        spec_dz_d  = 1'b0;
        spec_inv_d = 1'b0;
        if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
            spec_z_d   = NAN_CANON;
            spec_inv_d = 1'b1;
        end else if (x_inf) begin
            spec_z_d = {res_sign, INF_MAG};
        end else if (y_inf) begin
            spec_z_d = {res_sign, 31'd0};
        end else if (y_zero) begin
            spec_z_d  = {res_sign, INF_MAG};
            spec_dz_d = 1'b1;
        end else if (x_zero) begin
            spec_z_d = {res_sign, 31'd0};
        end else begin
            spec_d = 1'b0;
        end
    end

    // One restoring step; remainder stays below 2*my so 25 bits suffice
    logic [24:0] my_ext, rem_nx, rem_shl;
    logic        q_bit;
    assign my_ext  = {1'b0, my_q};
    assign q_bit   = (rem_q >= my_ext);
    assign rem_nx  = q_bit ? (rem_q - my_ext) : rem_q;
    assign rem_shl = rem_nx << 1;

    // Normalize + round; evaluated in NORM so the result is registered with done
    logic [22:0]       frac, frac_r;
    logic [23:0]       frac_sum;
    logic              g, r, s, inexact, inc, carry;
    logic signed [9:0] e_n, e_r;
    logic [31:0]       res_z_d;
    logic              res_ovf_d, res_udf_d, res_dz_d, res_inv_d;
    always_comb begin
        if (q_q[QBITS-1]) begin
            frac = q_q[QBITS-2 -: 23];
            g    = q_q[QBITS-25];
            r    = q_q[QBITS-26];
            s    = (|q_q[QBITS-27:0]) | (|rem_q);
            e_n  = exp_q;
        end else begin
            // Quotient below 1.0: its next bit is the hidden one
            frac = q_q[QBITS-3 -: 23];
            g    = q_q[QBITS-26];
            r    = q_q[QBITS-27];
            s    = |rem_q;
            e_n  = exp_q - 10'sd1;
        end
        inexact = g | r | s;
        case (rm_q)
            3'b001:  inc = 1'b0;
            3'b010:  inc = res_sign & inexact;
            3'b011:  inc = ~res_sign & inexact;
            3'b100:  inc = g;
            default: inc = g & (r | s | frac[0]);
        endcase
        frac_sum = {1'b0, frac} + {23'd0, inc};
        carry    = frac_sum[23];
        // On carry the fraction wraps to zero, i.e. mantissa 1.0 one binade up
        frac_r   = frac_sum[22:0];
        e_r      = carry ? (e_n + 10'sd1) : e_n;

        res_z_d   = {res_sign, e_r[7:0], frac_r};
        res_ovf_d = 1'b0;
        res_udf_d = 1'b0;
        res_dz_d  = 1'b0;
        res_inv_d = 1'b0;
        if (spec_q) begin
            res_z_d   = spec_z_q;
            res_dz_d  = spec_dz_q;
            res_inv_d = spec_inv_q;
        end else if (e_r >= 10'sd255) begin
            res_ovf_d = 1'b1;
            case (rm_q)
                3'b001:  res_z_d = {res_sign, MAX_MAG};
                3'b010:  res_z_d = res_sign ? {1'b1, INF_MAG} : {1'b0, MAX_MAG};
                3'b011:  res_z_d = res_sign ? {1'b1, MAX_MAG} : {1'b0, INF_MAG};
                default: res_z_d = {res_sign, INF_MAG};
            endcase
        end else if (e_r <= 10'sd0) begin
            res_udf_d = 1'b1;
            res_z_d   = {res_sign, 31'd0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            rm_q       <= '0;
            exp_q      <= '0;
            rem_q      <= '0;
            my_q       <= '0;
            q_q        <= '0;
            cnt_q      <= '0;
            spec_q     <= 1'b0;
            spec_z_q   <= '0;
            spec_dz_q  <= 1'b0;
            spec_inv_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            z_q        <= '0;
            ovrf_q     <= 1'b0;
            udrf_q     <= 1'b0;
            dz_q       <= 1'b0;
            inv_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x_q     <= fp_X;
                        y_q     <= fp_Y;
                        rm_q    <= r_mode;
                        busy_q  <= 1'b1;
                        state_q <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    exp_q      <= exp_d;
                    rem_q      <= {2'b01, xf};
                    my_q       <= {1'b1, yf};
                    q_q        <= '0;
                    cnt_q      <= CW'(QBITS - 1);
                    spec_q     <= spec_d;
                    spec_z_q   <= spec_z_d;
                    spec_dz_q  <= spec_dz_d;
                    spec_inv_q <= spec_inv_d;
`ifdef FP_DIV_FAST_SPECIAL_EN
                    if (spec_d) begin
                        z_q     <= spec_z_d;
                        ovrf_q  <= 1'b0;
                        udrf_q  <= 1'b0;
                        dz_q    <= spec_dz_d;
                        inv_q   <= spec_inv_d;
                        done_q  <= 1'b1;
                        state_q <= S_ROUND;
                    end else begin
                        state_q <= S_ITER;
                    end
`else
                    state_q <= S_ITER;
`endif
                end
                S_ITER: begin
                    q_q   <= {q_q[QBITS-2:0], q_bit};
                    rem_q <= rem_shl;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= S_NORM;
                    end
                end
                S_NORM: begin
                    z_q     <= res_z_d;
                    ovrf_q  <= res_ovf_d;
                    udrf_q  <= res_udf_d;
                    dz_q    <= res_dz_d;
                    inv_q   <= res_inv_d;
                    done_q  <= 1'b1;
                    state_q <= S_ROUND;
                end
                S_ROUND: begin
                    // Result is presented here; busy and done drop together
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign fp_Z = z_q;
    assign ovrf = ovrf_q;
    assign udrf = udrf_q;
    assign dz   = dz_q;
    assign inv  = inv_q;
endmodule

// File: tb/tb_fp_div_seq.sv
// Scoreboard bench for fp_div_seq: directed vectors push expectations, a monitor checks each done.
// Latency: expectations carry the exact cycle at which done must appear.
// Backpressure: stimulus waits for busy=0 before each new start.
module tb_fp_div_seq;
`ifdef FP_DIV_FAST_SPECIAL_EN
    localparam int LAT_SP = 2;
`else
    localparam int LAT_SP = 30;
`endif
    localparam int LAT_NORM = 30;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] fp_X, fp_Y;
    logic [2:0]  r_mode;
    logic        busy, done, ovrf, udrf, dz, inv;
    logic [31:0] fp_Z;

    fp_div_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .fp_X   (fp_X),
        .fp_Y   (fp_Y),
        .r_mode (r_mode),
        .busy   (busy),
        .done   (done),
        .fp_Z   (fp_Z),
        .ovrf   (ovrf),
        .udrf   (udrf),
        .dz     (dz),
        .inv    (inv)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       nm;
        logic [31:0] z;
        logic [3:0]  fl;   // {ovrf, udrf, dz, inv}
        int          due;
    } exp_t;

    typedef struct {
        string       nm;
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  rm;
        logic [31:0] z;
        logic [3:0]  fl;
        bit          sp;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                check({mon_e.nm, " z"}, fp_Z, mon_e.z);
                check({mon_e.nm, " flags"}, {28'd0, ovrf, udrf, dz, inv}, {28'd0, mon_e.fl});
                check({mon_e.nm, " cycle"}, 32'(cyc), 32'(mon_e.due));
                check({mon_e.nm, " busy"}, {31'd0, busy}, 32'd1);
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic issue(input vec_t v);
        exp_t e;
        wait_idle();
        fp_X   = v.x;
        fp_Y   = v.y;
        r_mode = v.rm;
        start  = 1'b1;
        e.nm   = v.nm;
        e.z    = v.z;
        e.fl   = v.fl;
        e.due  = cyc + (v.sp ? LAT_SP : LAT_NORM);
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((sbq.size() != 0 || busy) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (sbq.size() != 0) check("drain_timeout", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs.push_back('{"6div2",       32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 4'b0000, 1'b0});
        vecs.push_back('{"1div3_rne",   32'h3F800000, 32'h40400000, 3'b000, 32'h3EAAAAAB, 4'b0000, 1'b0});
        vecs.push_back('{"1div3_rtz",   32'h3F800000, 32'h40400000, 3'b001, 32'h3EAAAAAA, 4'b0000, 1'b0});
        vecs.push_back('{"1div3_rmm",   32'h3F800000, 32'h40400000, 3'b100, 32'h3EAAAAAB, 4'b0000, 1'b0});
        vecs.push_back('{"1div3_m101",  32'h3F800000, 32'h40400000, 3'b101, 32'h3EAAAAAB, 4'b0000, 1'b0});
        vecs.push_back('{"m1div3_rdn",  32'hBF800000, 32'h40400000, 3'b010, 32'hBEAAAAAB, 4'b0000, 1'b0});
        vecs.push_back('{"m1div3_rup",  32'hBF800000, 32'h40400000, 3'b011, 32'hBEAAAAAA, 4'b0000, 1'b0});
        vecs.push_back('{"1div0",       32'h3F800000, 32'h00000000, 3'b000, 32'h7F800000, 4'b0010, 1'b1});
        vecs.push_back('{"0div0",       32'h00000000, 32'h00000000, 3'b000, 32'h7FC00000, 4'b0001, 1'b1});
        vecs.push_back('{"1divsub",     32'h3F800000, 32'h00000001, 3'b000, 32'h7F800000, 4'b0010, 1'b1});
        vecs.push_back('{"infdiv0",     32'h7F800000, 32'h00000000, 3'b000, 32'h7F800000, 4'b0000, 1'b1});
        vecs.push_back('{"nan_op",      32'h7F800001, 32'h3F800000, 3'b000, 32'h7FC00000, 4'b0001, 1'b1});
        vecs.push_back('{"inf_inf",     32'hFF800000, 32'h7F800000, 3'b000, 32'h7FC00000, 4'b0001, 1'b1});
        vecs.push_back('{"1div_ninf",   32'h3F800000, 32'hFF800000, 3'b000, 32'h80000000, 4'b0000, 1'b1});
        vecs.push_back('{"negzero",     32'h80000000, 32'h3F800000, 3'b000, 32'h80000000, 4'b0000, 1'b1});
        vecs.push_back('{"ovf_rne",     32'h7F000000, 32'h3E800000, 3'b000, 32'h7F800000, 4'b1000, 1'b0});
        vecs.push_back('{"ovf_rtz",     32'h7F000000, 32'h3E800000, 3'b001, 32'h7F7FFFFF, 4'b1000, 1'b0});
        vecs.push_back('{"ovf_rdn_pos", 32'h7F000000, 32'h3E800000, 3'b010, 32'h7F7FFFFF, 4'b1000, 1'b0});
        vecs.push_back('{"ovf_rup_pos", 32'h7F000000, 32'h3E800000, 3'b011, 32'h7F800000, 4'b1000, 1'b0});
        vecs.push_back('{"ovf_rdn_neg", 32'hFF000000, 32'h3E800000, 3'b010, 32'hFF800000, 4'b1000, 1'b0});
        vecs.push_back('{"ovf_rup_neg", 32'hFF000000, 32'h3E800000, 3'b011, 32'hFF7FFFFF, 4'b1000, 1'b0});
        vecs.push_back('{"udf",         32'h00800000, 32'h7F000000, 3'b000, 32'h00000000, 4'b0100, 1'b0});
        vecs.push_back('{"udf_neg",     32'h80800000, 32'h7F000000, 3'b000, 32'h80000000, 4'b0100, 1'b0});

        start  = 1'b0;
        fp_X   = '0;
        fp_Y   = '0;
        r_mode = '0;
        rst    = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst busy",  {31'd0, busy}, 32'd0);
        check("rst done",  {31'd0, done}, 32'd0);
        check("rst fp_Z",  fp_Z, 32'd0);
        check("rst flags", {28'd0, ovrf, udrf, dz, inv}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) issue(vecs[i]);
        drain();

        // A start while busy must be ignored, operands included
        issue(vecs[0]);
        repeat (9) @(negedge clk);
        fp_X   = 32'h3F800000;
        fp_Y   = 32'h40400000;
        r_mode = 3'b001;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (40) @(negedge clk);
        check("ignored_start busy", {31'd0, busy}, 32'd0);

        // Reset in mid-operation aborts without a done
        issue(vecs[1]);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst busy", {31'd0, busy}, 32'd0);
        check("mid_rst fp_Z", fp_Z, 32'd0);
        check("mid_rst done", {31'd0, done}, 32'd0);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("post_rst busy", {31'd0, busy}, 32'd0);

        v = vecs[2];
        v.nm = "after_rst";
        issue(v);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
